// File: rtl/btn_debounce_sync.sv
// rtl/btn_debounce_sync.sv - 2-FF synchronizer plus counting debouncer with rise/fall pulses
module btn_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int CNT_WIDTH       = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic btn_in,
    output logic D_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic                 w_accept;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_d_out;
    logic                 r_rise;
    logic                 r_fall;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_d_out <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_d_out <= w_accept ? ~r_d_out : r_d_out;
            r_rise  <= w_accept & ~r_d_out;
            r_fall  <= w_accept & r_d_out;
        end
    end

    // Any sample matching the current level during CHECK throws the count away.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2 != r_d_out) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_next_state = CHECK;
                        w_next_cnt   = ONE_CNT;
                    end
                end
            end
            CHECK: begin
                if (r_sync2 == r_d_out) begin
                    w_next_state = IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + ONE_CNT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign D_out      = r_d_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = (r_state == CHECK);

endmodule

// File: tb/tb_btn_debounce_sync.sv
// tb/tb_btn_debounce_sync.sv - directed bench for btn_debounce_sync (DEBOUNCE_CYCLES 4 and 1)
module tb_btn_debounce_sync;

    logic Clk;
    logic reset;
    logic btn_in;
    logic D_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;
    logic d2_D_out;
    logic d2_rise;
    logic d2_fall;
    logic d2_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] busy_exp;

    btn_debounce_sync #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .D_out     (D_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    btn_debounce_sync #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .Clk       (Clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .D_out     (d2_D_out),
        .rise_pulse(d2_rise),
        .fall_pulse(d2_fall),
        .busy      (d2_busy)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".D_out"}, D_out, 1'b0);
        check({tag, ".rise"}, rise_pulse, 1'b0);
        check({tag, ".fall"}, fall_pulse, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        // Test 1: reset held, then asynchronous reset while outputs are high
        reset  = 1'b0;
        btn_in = 1'b1;
        #1;
        check_all_zero("t1_reset_t0");
        for (int i = 0; i < 3; i++) tick();
        check_all_zero("t1_reset_held");
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check("t1_e5_D_out", D_out, 1'b0);
        tick();
        check("t1_e6_D_out", D_out, 1'b1);
        check("t1_e6_rise", rise_pulse, 1'b1);
        #5;
        reset = 1'b0;
        #1;
        check_all_zero("t1_async_reset");

        // Test 2: clean press
        btn_in = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t2_idle_D_out", D_out, 1'b0);
        btn_in = 1'b1;
        tick();
        tick();
        check("t2_e2_busy", busy, 1'b0);
        tick();
        check("t2_e3_busy", busy, 1'b1);
        tick();
        tick();
        check("t2_e5_D_out", D_out, 1'b0);
        tick();
        check("t2_e6_D_out", D_out, 1'b1);
        check("t2_e6_rise", rise_pulse, 1'b1);
        check("t2_e6_fall", fall_pulse, 1'b0);
        check("t2_e6_busy", busy, 1'b0);
        tick();
        check("t2_e7_rise", rise_pulse, 1'b0);
        check("t2_e7_fall", fall_pulse, 1'b0);
        check("t2_e7_D_out", D_out, 1'b1);

        // Test 5: release
        btn_in = 1'b0;
        tick();
        tick();
        tick();
        check("t5_e3_busy", busy, 1'b1);
        tick();
        tick();
        check("t5_e5_D_out", D_out, 1'b1);
        check("t5_e5_fall", fall_pulse, 1'b0);
        tick();
        check("t5_e6_D_out", D_out, 1'b0);
        check("t5_e6_fall", fall_pulse, 1'b1);
        check("t5_e6_rise", rise_pulse, 1'b0);
        tick();
        check("t5_e7_fall", fall_pulse, 1'b0);

        // Test 3: bouncy press; edge1 catches 1, edge2 catches 0, then high from before edge3
        #15 btn_in = 1'b1;
        #5  btn_in = 1'b0;
        #5  btn_in = 1'b1;
        #5  btn_in = 1'b0;
        @(posedge Clk);
        #1;
        check("t3_e2_busy", busy, 1'b0);
        #15 btn_in = 1'b1;
        tick();
        check("t3_e3_busy", busy, 1'b1);
        tick();
        check("t3_e4_busy", busy, 1'b0);
        check("t3_e4_D_out", D_out, 1'b0);
        tick();
        check("t3_e5_busy", busy, 1'b1);
        tick();
        tick();
        check("t3_e7_D_out", D_out, 1'b0);
        tick();
        check("t3_e8_D_out", D_out, 1'b1);
        check("t3_e8_rise", rise_pulse, 1'b1);

        btn_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t3_back_low", D_out, 1'b0);

        // Test 4: 3-cycle glitch never accepted
        busy_exp = 8'b0001_1100;
        btn_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t4_e%0d_D_out", i), D_out, 1'b0);
            check($sformatf("t4_e%0d_rise", i), rise_pulse, 1'b0);
            check($sformatf("t4_e%0d_busy", i), busy, busy_exp[i-1]);
            if (i == 3) btn_in = 1'b0;
        end

        // Test 6: reset mid-CHECK at cnt=2, both parameterisations
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_pre_busy", busy, 1'b1);
        check("t6_pre_d1_D_out", d2_D_out, 1'b1);
        #4 reset = 1'b0;
        #1;
        check_all_zero("t6_reset");
        check("t6_reset_d1_D_out", d2_D_out, 1'b0);
        #4 reset = 1'b1;
        tick();
        tick();
        check("t6_e2_d1_D_out", d2_D_out, 1'b0);
        tick();
        check("t6_e3_d1_D_out", d2_D_out, 1'b1);
        check("t6_e3_d1_rise", d2_rise, 1'b1);
        check("t6_e3_d1_busy", d2_busy, 1'b0);
        tick();
        check("t6_e4_d1_rise", d2_rise, 1'b0);
        tick();
        check("t6_e5_D_out", D_out, 1'b0);
        tick();
        check("t6_e6_D_out", D_out, 1'b1);
        check("t6_e6_rise", rise_pulse, 1'b1);
        check("t6_e6_d1_fall", d2_fall, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
